// File: rtl/hit_referee.sv
// -----------------------------------------------------------------------------
// hit_referee
//
// Purpose:
//   Referees projectile hits between the cat and the dog and runs the
//   end-of-round sequence.
//   - Detects a projectile overlapping its opponent's hitbox and issues a
//     one-cycle damage pulse plus a despawn request.
//   - Applies per-target invulnerability frames.
//   - Allows at most one hit per target per frame.
//   - Watches the hp read-back and sequences KO -> RESET -> ARM -> FIGHT.
//   Runs on the pixel clock. The rising edge of vsync is the frame tick.
//
// Configuration macro:
//   CVD_AUTO_RESTART_EN
//     Defined:   KO ends after KO_FRAMES frame ticks, or earlier on restart.
//     Undefined: KO holds until restart. The frame counter is not built.
//
// Ports:
//   clk          in   1   pixel clock
//   rst          in   1   synchronous active-high reset
//   vsync        in   1   VGA vsync; rising edge = frame tick
//   proj_valid   in   1   projectile in flight
//   proj_owner   in   1   0 = thrown by cat, 1 = thrown by dog
//   proj_x/y     in   11  projectile top-left corner
//   cat_x/y      in   11  cat hitbox top-left corner
//   dog_x/y      in   11  dog hitbox top-left corner
//   hp_cat/dog   in   10  hp read back from the health bars
//   restart      in   1   manual restart pulse, honoured only in KO
//   hit_cat      out  1   1-cycle damage pulse to cat
//   hit_dog      out  1   1-cycle damage pulse to dog
//   proj_consume out  1   1-cycle despawn request
//   reset_hp     out  1   1-cycle hp restore request
//   round_over   out  1   high while in KO
//   winner       out  2   00 none, 01 cat, 10 dog, 11 draw
// -----------------------------------------------------------------------------
module hit_referee #(
   parameter int CHAR_W     = 128,
   parameter int CHAR_H     = 128,
   parameter int PROJ_SIZE  = 16,
   parameter int IFRAMES    = 30,
`ifdef CVD_AUTO_RESTART_EN
   parameter int KO_FRAMES  = 180,
`endif
   parameter int HEALTH_MAX = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        proj_valid,
   input  logic        proj_owner,
   input  logic [10:0] proj_x,
   input  logic [10:0] proj_y,
   input  logic [10:0] cat_x,
   input  logic [10:0] cat_y,
   input  logic [10:0] dog_x,
   input  logic [10:0] dog_y,
   input  logic [9:0]  hp_cat,
   input  logic [9:0]  hp_dog,
   input  logic        restart,
   output logic        hit_cat,
   output logic        hit_dog,
   output logic        proj_consume,
   output logic        reset_hp,
   output logic        round_over,
   output logic [1:0]  winner
);

   typedef enum logic [1:0] {
      ST_FIGHT = 2'd0,
      ST_KO    = 2'd1,
      ST_RESET = 2'd2,
      ST_ARM   = 2'd3
   } state_t;

   localparam int              CD_W    = $clog2(IFRAMES + 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(IFRAMES);
   localparam logic [CD_W-1:0] CD_ZERO = {CD_W{1'b0}};
   localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
   localparam logic [11:0]     BOX_W12 = 12'(CHAR_W);
   localparam logic [11:0]     BOX_H12 = 12'(CHAR_H);
   localparam logic [11:0]     PROJ12  = 12'(PROJ_SIZE);
   localparam logic [9:0]      HP_FULL = 10'(HEALTH_MAX);
   localparam logic [9:0]      HP_ZERO = 10'd0;

`ifdef CVD_AUTO_RESTART_EN
   localparam int              KO_W    = $clog2(KO_FRAMES + 1);
   localparam logic [KO_W-1:0] KO_LAST = KO_W'(KO_FRAMES - 1);
   localparam logic [KO_W-1:0] KO_ONE  = KO_W'(1);
   localparam logic [KO_W-1:0] KO_ZERO = {KO_W{1'b0}};
`endif

   // Winner encoding on KO entry: the side still standing wins, both down is a draw.
   function automatic logic [1:0] ko_winner(input logic cat_down, input logic dog_down);
      logic [1:0] w;
      case ({cat_down, dog_down})
         2'b01:   w = 2'b01;
         2'b10:   w = 2'b10;
         2'b11:   w = 2'b11;
         default: w = 2'b00;
      endcase
      return w;
   endfunction

   state_t          state_q, state_d;
   logic            vsync_q, vsync_d;
   logic [CD_W-1:0] cd_cat_q, cd_cat_d;
   logic [CD_W-1:0] cd_dog_q, cd_dog_d;
   logic            flag_cat_q, flag_cat_d;
   logic            flag_dog_q, flag_dog_d;
   logic            hit_cat_q, hit_cat_d;
   logic            hit_dog_q, hit_dog_d;
   logic            consume_q, consume_d;
   logic            reset_hp_q, reset_hp_d;
   logic            round_over_q, round_over_d;
   logic [1:0]      winner_q, winner_d;
`ifdef CVD_AUTO_RESTART_EN
   logic [KO_W-1:0] ko_cnt_q, ko_cnt_d;
`endif

   logic            tick;
   logic            overlap;
   logic            hit_cat_req;
   logic            hit_dog_req;
   logic [11:0]     box_x, box_y, px, py;

   assign tick = vsync & ~vsync_q;

   // AABB test of the projectile against the opponent box only, widened to 12 bits so sums never wrap.
   always_comb begin
      px      = {1'b0, proj_x};
      py      = {1'b0, proj_y};
      box_x   = proj_owner ? {1'b0, cat_x} : {1'b0, dog_x};
      box_y   = proj_owner ? {1'b0, cat_y} : {1'b0, dog_y};
      overlap = (px < box_x + BOX_W12) && (px + PROJ12 > box_x) &&
                (py < box_y + BOX_H12) && (py + PROJ12 > box_y);
   end

   // The owner selects a single target, so one projectile can raise at most one hit.
   assign hit_cat_req = proj_valid & proj_owner & overlap & (cd_cat_q == CD_ZERO) &
                        ~flag_cat_q & (state_q == ST_FIGHT);
   assign hit_dog_req = proj_valid & ~proj_owner & overlap & (cd_dog_q == CD_ZERO) &
                        ~flag_dog_q & (state_q == ST_FIGHT);

   // Next-state logic for cooldowns, per-frame flags, the round FSM and all registered outputs.
   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      vsync_d    = vsync;
`ifdef CVD_AUTO_RESTART_EN
      ko_cnt_d   = ko_cnt_q;
`endif
      hit_cat_d  = hit_cat_req;
      hit_dog_d  = hit_dog_req;
      consume_d  = hit_cat_req | hit_dog_req;

      // A hit reloads the cooldown; otherwise it counts frames down to zero.
      cd_cat_d   = hit_cat_req ? CD_LOAD :
                   ((tick && (cd_cat_q != CD_ZERO)) ? cd_cat_q - CD_ONE : cd_cat_q);
      cd_dog_d   = hit_dog_req ? CD_LOAD :
                   ((tick && (cd_dog_q != CD_ZERO)) ? cd_dog_q - CD_ONE : cd_dog_q);

      // A hit in the same cycle as a tick wins, leaving the flag set.
      flag_cat_d = hit_cat_req | (flag_cat_q & ~tick);
      flag_dog_d = hit_dog_req | (flag_dog_q & ~tick);

      case (state_q)
         ST_FIGHT: begin
            if ((hp_cat == HP_ZERO) || (hp_dog == HP_ZERO)) begin
               state_d  = ST_KO;
               winner_d = ko_winner(hp_cat == HP_ZERO, hp_dog == HP_ZERO);
`ifdef CVD_AUTO_RESTART_EN
               ko_cnt_d = KO_ZERO;
`endif
            end else begin
               state_d  = ST_FIGHT;
            end
         end
         ST_KO: begin
`ifdef CVD_AUTO_RESTART_EN
            if (restart) begin
               state_d  = ST_RESET;
            end else if (tick && (ko_cnt_q == KO_LAST)) begin
               state_d  = ST_RESET;
            end else if (tick) begin
               ko_cnt_d = ko_cnt_q + KO_ONE;
            end else begin
               state_d  = ST_KO;
            end
`else
            if (restart) begin
               state_d = ST_RESET;
            end else begin
               state_d = ST_KO;
            end
`endif
         end
         ST_RESET: begin
            state_d    = ST_ARM;
            cd_cat_d   = CD_ZERO;
            cd_dog_d   = CD_ZERO;
            flag_cat_d = 1'b0;
            flag_dog_d = 1'b0;
         end
         ST_ARM: begin
            if ((hp_cat == HP_FULL) && (hp_dog == HP_FULL)) begin
               state_d  = ST_FIGHT;
               winner_d = 2'b00;
            end else begin
               state_d  = ST_ARM;
            end
         end
         default: begin
            state_d = ST_FIGHT;
         end
      endcase

      // Outputs follow the state being entered, so they line up with it.
      round_over_d = (state_d == ST_KO);
      reset_hp_d   = (state_d == ST_RESET);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FIGHT;
         vsync_q      <= 1'b0;
         cd_cat_q     <= CD_ZERO;
         cd_dog_q     <= CD_ZERO;
         flag_cat_q   <= 1'b0;
         flag_dog_q   <= 1'b0;
         hit_cat_q    <= 1'b0;
         hit_dog_q    <= 1'b0;
         consume_q    <= 1'b0;
         reset_hp_q   <= 1'b0;
         round_over_q <= 1'b0;
         winner_q     <= 2'b00;
`ifdef CVD_AUTO_RESTART_EN
         ko_cnt_q     <= KO_ZERO;
`endif
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync_d;
         cd_cat_q     <= cd_cat_d;
         cd_dog_q     <= cd_dog_d;
         flag_cat_q   <= flag_cat_d;
         flag_dog_q   <= flag_dog_d;
         hit_cat_q    <= hit_cat_d;
         hit_dog_q    <= hit_dog_d;
         consume_q    <= consume_d;
         reset_hp_q   <= reset_hp_d;
         round_over_q <= round_over_d;
         winner_q     <= winner_d;
`ifdef CVD_AUTO_RESTART_EN
         ko_cnt_q     <= ko_cnt_d;
`endif
      end
   end

   assign hit_cat      = hit_cat_q;
   assign hit_dog      = hit_dog_q;
   assign proj_consume = consume_q;
   assign reset_hp     = reset_hp_q;
   assign round_over   = round_over_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_hit_referee.sv
// -----------------------------------------------------------------------------
// tb_hit_referee
//
// Directed bench for hit_referee. Inputs are driven 1 time unit after the
// rising edge. Outputs are sampled there too, so each step() shows the
// registered response to the inputs of the previous cycle. A frame is 4
// cycles, and vsync is high in the first of them.
// -----------------------------------------------------------------------------
module tb_hit_referee;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        proj_valid;
   logic        proj_owner;
   logic [10:0] proj_x, proj_y;
   logic [10:0] cat_x, cat_y;
   logic [10:0] dog_x, dog_y;
   logic [9:0]  hp_cat, hp_dog;
   logic        restart;
   logic        hit_cat, hit_dog, proj_consume, reset_hp, round_over;
   logic [1:0]  winner;

   int n_checks = 0;
   int n_errors = 0;
   int frame_no = 0;
   int cnt_hit_cat = 0;
   int cnt_hit_dog = 0;
   int cnt_consume = 0;
   int cnt_reset_hp = 0;
   int cat_hit_frame [2];

   hit_referee dut (
      .clk          (clk),
      .rst          (rst),
      .vsync        (vsync),
      .proj_valid   (proj_valid),
      .proj_owner   (proj_owner),
      .proj_x       (proj_x),
      .proj_y       (proj_y),
      .cat_x        (cat_x),
      .cat_y        (cat_y),
      .dog_x        (dog_x),
      .dog_y        (dog_y),
      .hp_cat       (hp_cat),
      .hp_dog       (hp_dog),
      .restart      (restart),
      .hit_cat      (hit_cat),
      .hit_dog      (hit_dog),
      .proj_consume (proj_consume),
      .reset_hp     (reset_hp),
      .round_over   (round_over),
      .winner       (winner)
   );

   always #5 clk = ~clk;

   // Count output pulses and note the frame numbers of the first two cat hits.
   always @(negedge clk) begin
      if (hit_cat) begin
         if (cnt_hit_cat < 2) cat_hit_frame[cnt_hit_cat] = frame_no;
         cnt_hit_cat = cnt_hit_cat + 1;
      end
      if (hit_dog)      cnt_hit_dog  = cnt_hit_dog + 1;
      if (proj_consume) cnt_consume  = cnt_consume + 1;
      if (reset_hp)     cnt_reset_hp = cnt_reset_hp + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         vsync = 1'b1;
         frame_no = frame_no + 1;
         step();
         vsync = 1'b0;
         step();
         step();
         step();
      end
   endtask

   task automatic clear_counts();
      cnt_hit_cat  = 0;
      cnt_hit_dog  = 0;
      cnt_consume  = 0;
      cnt_reset_hp = 0;
   endtask

   task automatic set_proj(input logic owner, input int x, input int y);
      proj_valid = 1'b1;
      proj_owner = owner;
      proj_x     = 11'(x);
      proj_y     = 11'(y);
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b0; proj_valid = 1'b0; proj_owner = 1'b0;
      proj_x = 11'd0; proj_y = 11'd0;
      cat_x = 11'd150; cat_y = 11'd250;
      dog_x = 11'd600; dog_y = 11'd400;
      hp_cat = 10'd500; hp_dog = 10'd500; restart = 1'b0;
      #1;
      step();
      step();
      check("rst_hit_cat", hit_cat, 0);
      check("rst_round_over", round_over, 0);
      check("rst_winner", winner, 0);
      check("rst_reset_hp", reset_hp, 0);
      rst = 1'b0;
      step();
      clear_counts();

      // Dog throws onto the cat: a single pulse one cycle later, with consume.
      set_proj(1'b1, 200, 300);
      #1;
      check("hit_lat_zero", hit_cat, 0);
      step();
      check("hit_cat_pulse", hit_cat, 1);
      check("consume_pulse", proj_consume, 1);
      check("hit_dog_quiet", hit_dog, 0);
      step();
      check("hit_cat_1cyc", hit_cat, 0);

      // Overlap held for 40 frames: exactly two hits, 30 frames apart.
      run_frames(40);
      check("iframe_hits", cnt_hit_cat, 2);
      check("iframe_space", cat_hit_frame[1] - cat_hit_frame[0], 30);

      // Cat throws while over the cat: it is tested against the dog only.
      clear_counts();
      proj_owner = 1'b0;
      run_frames(2);
      check("no_self_hit_dog", cnt_hit_dog, 0);
      check("no_self_hit_cons", cnt_consume, 0);

      // Edge boundaries against the dog at (600,400): touching is not overlapping.
      set_proj(1'b0, 728, 400); step(); step();
      set_proj(1'b0, 584, 400); step(); step();
      set_proj(1'b0, 600, 528); step(); step();
      set_proj(1'b0, 600, 384); step(); step();
      check("edge_no_hit", cnt_hit_dog, 0);
      set_proj(1'b0, 727, 527);
      step();
      check("corner_hit_dog", hit_dog, 1);
      check("corner_no_cat", hit_cat, 0);

      // Let the cat cooldown expire, then confirm sums near x=2047 do not wrap.
      proj_valid = 1'b0;
      run_frames(30);
      cat_x = 11'd2000; cat_y = 11'd100;
      set_proj(1'b1, 2040, 150);
      step();
      check("wide_sum_hit", hit_cat, 1);
      proj_valid = 1'b0;
      cat_x = 11'd150; cat_y = 11'd250;
      step();

      // Dog hp at 0 leads to KO with the cat as winner.
      hp_dog = 10'd0;
      step();
      check("ko_round_over", round_over, 1);
      check("ko_winner_cat", winner, 1);
      clear_counts();
`ifdef CVD_AUTO_RESTART_EN
      run_frames(179);
      check("auto_no_early", cnt_reset_hp, 0);
      check("auto_still_ko", round_over, 1);
      run_frames(1);
      check("auto_reset_once", cnt_reset_hp, 1);
`else
      run_frames(500);
      check("man_hold_no_rst", cnt_reset_hp, 0);
      check("man_hold_ko", round_over, 1);
      restart = 1'b1;
      step();
      check("man_reset_hp", reset_hp, 1);
      restart = 1'b0;
`endif
      step();
      check("reset_hp_1cyc", reset_hp, 0);
      check("arm_not_ko", round_over, 0);

      // ARM ignores projectiles while waiting for full hp.
      clear_counts();
      set_proj(1'b1, 200, 300);
      step(); step(); step();
      check("arm_no_hit", cnt_hit_cat, 0);
      proj_valid = 1'b0;
      hp_dog = 10'd500;
      step();
      check("fight_winner0", winner, 0);
      check("fight_round0", round_over, 0);

      // A restart request outside KO has no effect.
      restart = 1'b1;
      step();
      check("restart_ignored", reset_hp, 0);
      restart = 1'b0;

      // Cat hit starts a cooldown, then cat hp 0 enters KO with the dog as winner.
      set_proj(1'b1, 200, 300);
      step();
      check("pre_ko_hit", hit_cat, 1);
      proj_valid = 1'b0;
      hp_cat = 10'd0;
      step();
      check("ko_winner_dog", winner, 2);

      // Reset in mid-KO and mid-cooldown clears everything, and a hit follows at once.
      rst = 1'b1;
      hp_cat = 10'd500;
      step();
      check("mid_rst_round", round_over, 0);
      check("mid_rst_winner", winner, 0);
      check("mid_rst_hit", hit_cat, 0);
      rst = 1'b0;
      set_proj(1'b1, 200, 300);
      step();
      check("post_rst_hit", hit_cat, 1);
      proj_valid = 1'b0;

      // Both fighters at 0 in the same cycle is a draw, and restart leaves KO.
      hp_cat = 10'd0; hp_dog = 10'd0;
      step();
      check("ko_draw", winner, 3);
      check("ko_draw_round", round_over, 1);
      restart = 1'b1;
      step();
      check("restart_reset_hp", reset_hp, 1);
      restart = 1'b0;
      step();
      check("restart_1cyc", reset_hp, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
